// File: rtl/router_pkt_fifo.sv
// Packet-aware output-channel FIFO: stores words with a start-of-packet tag and
// tracks packet boundaries on the read side via a remaining-word counter.
module router_pkt_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int LEN_LSB   = 2,
  parameter int LEN_W     = 6,
  parameter int AF_THRESH = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     soft_reset,
  input  logic                     write_en,
  input  logic                     sop_in,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     read_en,
  output logic [DATA_W-1:0]        data_out,
  output logic                     out_valid,
  output logic                     sop_out,
  output logic                     eop_out,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     pkt_active,
  output logic                     err_ovf,
  output logic                     err_udf,
  output logic                     err_trunc,
  output logic                     err_orphan
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] AF_LEVEL = (ADDR_W+1)'(AF_THRESH);
  localparam logic [LEN_W:0]  REM_ONE  = (LEN_W+1)'(1);

  // Bit DATA_W of each entry carries the start-of-packet tag.
  logic [DATA_W:0] mem [DEPTH];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [LEN_W:0]    rem_q, rem_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              out_valid_q, out_valid_d;
  logic              sop_out_q, sop_out_d;
  logic              eop_out_q, eop_out_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_udf_q, err_udf_d;
  logic              err_trunc_q, err_trunc_d;
  logic              err_orphan_q, err_orphan_d;

  logic              empty_w;
  logic              full_w;
  logic [ADDR_W:0]   level_w;
  logic              wr_fire;
  logic              rd_fire;
  logic [DATA_W:0]   rd_word;
  logic [LEN_W-1:0]  len_field;

  assign empty_w   = (rd_ptr_q == wr_ptr_q);
  assign full_w    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign level_w   = wr_ptr_q - rd_ptr_q;

  // Both decisions use pre-edge occupancy: no same-cycle space release or bypass.
  assign wr_fire   = write_en && !full_w && !soft_reset;
  assign rd_fire   = read_en && !empty_w && !soft_reset;

  assign rd_word   = mem[rd_ptr_q[ADDR_W-1:0]];
  assign len_field = rd_word[LEN_LSB+LEN_W-1:LEN_LSB];

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= {sop_in, data_in};
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rem_d        = rem_q;
    data_out_d   = data_out_q;
    out_valid_d  = 1'b0;
    sop_out_d    = sop_out_q;
    eop_out_d    = eop_out_q;
    err_ovf_d    = 1'b0;
    err_udf_d    = 1'b0;
    err_trunc_d  = 1'b0;
    err_orphan_d = 1'b0;

    if (soft_reset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      rem_d      = '0;
      data_out_d = '0;
      sop_out_d  = 1'b0;
      eop_out_d  = 1'b0;
    end else begin
      err_ovf_d = write_en && full_w;
      err_udf_d = read_en && empty_w;

      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end

      if (rd_fire) begin
        rd_ptr_d    = rd_ptr_q + PTR_ONE;
        data_out_d  = rd_word[DATA_W-1:0];
        sop_out_d   = rd_word[DATA_W];
        out_valid_d = 1'b1;
        eop_out_d   = 1'b0;
        if (rd_word[DATA_W]) begin
          // Header length counts payload words; +1 covers the trailing parity word.
          err_trunc_d = (rem_q != '0);
          rem_d       = {1'b0, len_field} + REM_ONE;
        end else if (rem_q != '0) begin
          eop_out_d = (rem_q == REM_ONE);
          rem_d     = rem_q - REM_ONE;
        end else begin
          err_orphan_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rem_q        <= '0;
      data_out_q   <= '0;
      out_valid_q  <= 1'b0;
      sop_out_q    <= 1'b0;
      eop_out_q    <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_udf_q    <= 1'b0;
      err_trunc_q  <= 1'b0;
      err_orphan_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rem_q        <= rem_d;
      data_out_q   <= data_out_d;
      out_valid_q  <= out_valid_d;
      sop_out_q    <= sop_out_d;
      eop_out_q    <= eop_out_d;
      err_ovf_q    <= err_ovf_d;
      err_udf_q    <= err_udf_d;
      err_trunc_q  <= err_trunc_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  assign data_out    = data_out_q;
  assign out_valid   = out_valid_q;
  assign sop_out     = sop_out_q;
  assign eop_out     = eop_out_q;
  assign empty       = empty_w;
  assign full        = full_w;
  assign level       = level_w;
  assign almost_full = (level_w >= AF_LEVEL);
  assign pkt_active  = (rem_q != '0);
  assign err_ovf     = err_ovf_q;
  assign err_udf     = err_udf_q;
  assign err_trunc   = err_trunc_q;
  assign err_orphan  = err_orphan_q;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed and random stimulus for router_pkt_fifo, checked cycle by cycle
// against a queue-based packet model.
module tb_router_pkt_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              soft_reset = 1'b0;
  logic              write_en = 1'b0;
  logic              sop_in = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              read_en = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              out_valid, sop_out, eop_out, empty, full, almost_full;
  logic [ADDR_W:0]   level;
  logic              pkt_active, err_ovf, err_udf, err_trunc, err_orphan;

  router_pkt_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .soft_reset(soft_reset),
    .write_en(write_en), .sop_in(sop_in), .data_in(data_in), .read_en(read_en),
    .data_out(data_out), .out_valid(out_valid), .sop_out(sop_out), .eop_out(eop_out),
    .empty(empty), .full(full), .almost_full(almost_full), .level(level),
    .pkt_active(pkt_active), .err_ovf(err_ovf), .err_udf(err_udf),
    .err_trunc(err_trunc), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [DATA_W:0]   mq[$];
  int                m_rem;
  logic [DATA_W-1:0] e_dout;
  bit e_valid, e_sop, e_eop, e_ovf, e_udf, e_trunc, e_orphan;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_rem = 0;
    e_dout = '0;
    e_valid = 0; e_sop = 0; e_eop = 0;
    e_ovf = 0; e_udf = 0; e_trunc = 0; e_orphan = 0;
  endtask

  task automatic model_step(input bit w, input bit s, input logic [DATA_W-1:0] d,
                            input bit r, input bit sr);
    bit was_full, was_empty;
    logic [DATA_W:0] word;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    e_valid = 0; e_ovf = 0; e_udf = 0; e_trunc = 0; e_orphan = 0;
    if (sr) begin
      model_clear();
      return;
    end
    e_ovf = w && was_full;
    e_udf = r && was_empty;
    if (r && !was_empty) begin
      word    = mq.pop_front();
      e_valid = 1;
      e_dout  = word[DATA_W-1:0];
      e_sop   = word[DATA_W];
      e_eop   = 0;
      if (word[DATA_W]) begin
        e_trunc = (m_rem != 0);
        m_rem   = ((int'(word[DATA_W-1:0]) >> 2) & 63) + 1;
      end else if (m_rem > 0) begin
        e_eop = (m_rem == 1);
        m_rem = m_rem - 1;
      end else begin
        e_orphan = 1;
      end
    end
    if (w && !was_full) mq.push_back({s, d});
  endtask

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("data_out", 32'(data_out), 32'(e_dout));
    if (e_valid) begin
      chk("sop_out", 32'(sop_out), 32'(e_sop));
      chk("eop_out", 32'(eop_out), 32'(e_eop));
    end
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("level", 32'(level), 32'(mq.size()));
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= DEPTH - 2));
    chk("pkt_active", 32'(pkt_active), 32'(m_rem != 0));
    chk("err_ovf", 32'(err_ovf), 32'(e_ovf));
    chk("err_udf", 32'(err_udf), 32'(e_udf));
    chk("err_trunc", 32'(err_trunc), 32'(e_trunc));
    chk("err_orphan", 32'(err_orphan), 32'(e_orphan));
  endtask

  task automatic cycle(input bit w, input bit s, input logic [DATA_W-1:0] d,
                       input bit r, input bit sr);
    write_en = w; sop_in = s; data_in = d; read_en = r; soft_reset = sr;
    @(posedge clk);
    #1;
    model_step(w, s, d, r, sr);
    write_en = 0; sop_in = 0; read_en = 0; soft_reset = 0;
    check_all();
  endtask

  initial begin
    int written;
    bit w, r;
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_empty", 32'(empty), 32'd1);
    resetn = 1'b1;

    // One packet: header len=3, three payload words, parity
    cycle(1, 1, 8'h0C, 0, 0);
    cycle(1, 0, 8'hA1, 0, 0);
    cycle(1, 0, 8'hA2, 0, 0);
    cycle(1, 0, 8'hA3, 0, 0);
    cycle(1, 0, 8'h5F, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    chk("pkt_sop_first", 32'(sop_out), 32'd1);
    chk("pkt_active_hdr", 32'(pkt_active), 32'd1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 1, 0);
    chk("pkt_eop_early", 32'(eop_out), 32'd0);
    cycle(0, 0, 8'h00, 1, 0);
    chk("pkt_eop_last", 32'(eop_out), 32'd1);
    chk("pkt_parity", 32'(data_out), 32'h5F);
    chk("pkt_active_end", 32'(pkt_active), 32'd0);

    // Fill to DEPTH, then overflow
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, 0, 8'(i + 8'h30), 0, 0);
      if (i == 12) chk("af_at_13", 32'(almost_full), 32'd0);
      if (i == 13) chk("af_at_14", 32'(almost_full), 32'd1);
    end
    cycle(1, 0, 8'hEE, 0, 0);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_pulse", 32'(err_ovf), 32'd1);
    chk("ovf_level", 32'(level), 32'd16);
    cycle(1, 0, 8'hEF, 1, 0);
    chk("full_rd_wr_level", 32'(level), 32'd15);
    while (mq.size() > 0) cycle(0, 0, 8'h00, 1, 0);

    // Simultaneous read+write at level 5
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'h60 + i), 0, 0);
    cycle(1, 0, 8'h70, 1, 0);
    chk("rdwr_level5", 32'(level), 32'd5);
    while (mq.size() > 0) cycle(0, 0, 8'h00, 1, 0);

    // Wrap: 40 words with interleaved reads
    written = 0;
    while (written < 40) begin
      w = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 1) == 1);
      if (w && mq.size() < DEPTH) written++;
      cycle(w, ($urandom_range(0, 3) == 0), 8'($urandom), r, 0);
    end
    while (mq.size() > 0) cycle(0, 0, 8'h00, 1, 0);

    // Error pulses
    cycle(0, 0, 8'h00, 1, 0);
    chk("udf_pulse", 32'(err_udf), 32'd1);
    cycle(1, 1, 8'h0C, 0, 0);
    cycle(1, 0, 8'h11, 0, 0);
    cycle(1, 1, 8'h04, 0, 0);
    cycle(1, 0, 8'h22, 0, 0);
    cycle(1, 0, 8'h33, 0, 0);
    cycle(1, 0, 8'h44, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    cycle(0, 0, 8'h00, 1, 0);
    cycle(0, 0, 8'h00, 1, 0);
    chk("trunc_pulse", 32'(err_trunc), 32'd1);
    cycle(0, 0, 8'h00, 1, 0);
    cycle(0, 0, 8'h00, 1, 0);
    chk("trunc_reload_eop", 32'(eop_out), 32'd1);
    cycle(0, 0, 8'h00, 1, 0);
    chk("orphan_pulse", 32'(err_orphan), 32'd1);
    chk("orphan_data", 32'(data_out), 32'h44);

    // soft_reset with 7 words stored and both requests high
    for (int i = 0; i < 7; i++) cycle(1, (i == 0), 8'(8'h80 + i), 0, 0);
    cycle(1, 0, 8'h99, 1, 1);
    chk("srst_level", 32'(level), 32'd0);
    chk("srst_empty", 32'(empty), 32'd1);
    chk("srst_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) cycle(1, 0, 8'(8'hC0 + i), 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    read_en = 1; write_en = 1; data_in = 8'hDD;
    #2;
    resetn = 1'b0;
    #1;
    model_clear();
    check_all();
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    read_en = 0; write_en = 0;
    @(posedge clk);
    #1;
    check_all();
    resetn = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0), 8'($urandom),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 63) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
